// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending transaction controller:
// coin codes, FSM state encoding and coin value decoding.
package vend_pkg;

    localparam logic [1:0] COIN_25   = 2'b00;
    localparam logic [1:0] COIN_50   = 2'b01;
    localparam logic [1:0] COIN_100  = 2'b10;
    localparam logic [1:0] COIN_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_VEND    = 2'b10,
        ST_CHANGE  = 2'b11
    } vend_state_e;

    // Value of one coin code in 25c units; COIN_NONE is worth nothing.
    function automatic logic [2:0] coin_units(input logic [1:0] code);
        logic [2:0] units_s;
        case (code)
            COIN_25:  units_s = 3'd1;
            COIN_50:  units_s = 3'd2;
            COIN_100: units_s = 3'd4;
            default:  units_s = 3'd0;
        endcase
        return units_s;
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; expire flags the enabled cycle in which the count
// would run out, so the owner can act on that same clock edge.
module vend_timer
    import vend_pkg::*;
#(
    parameter int W        = 8,
    parameter int LOAD_VAL = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [W-1:0] count_r;

    // Count register: load wins over decrement, stops at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= W'(LOAD_VAL);
        end else if (load) begin
            count_r <= W'(LOAD_VAL);
        end else if (en && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = en && !load && (count_r == W'(1));

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin credit, slot selection against
// per-slot prices, dispense handshake with timeout, and coin-by-coin change.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 8,
    parameter int PRICE0     = 2,
    parameter int PRICE1     = 3,
    parameter int PRICE2     = 4,
    parameter int PRICE3     = 6,
    parameter int IDLE_TO    = 1280,
    parameter int ACK_TO     = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [1:0]          sel_slot,
    input  logic                disp_ack,
    output logic                disp_req,
    output logic [1:0]          disp_slot,
    output logic                chg_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_rej,
    output logic                sel_nak,
    output logic                disp_fault,
    output logic                busy
);

    localparam int CW1    = CREDIT_W + 1;
    localparam int IDLE_W = $clog2(IDLE_TO + 1);
    localparam int ACK_W  = $clog2(ACK_TO + 1);
    localparam logic [CREDIT_W:0] MAX_C = CW1'(MAX_CREDIT);

    logic [1:0]        rst_sync_r;
    logic              run_s;
    vend_state_e       state_r, state_nxt_s;
    // One guard bit above the visible credit so cap checks cannot wrap.
    logic [CREDIT_W:0] credit_r, credit_nxt_s, sum_s;
    logic [CREDIT_W:0] price_r, price_nxt_s, sel_price_s;
    logic [1:0]        disp_slot_r, disp_slot_nxt_s;
    logic              disp_req_r, chg_pulse_r, coin_rej_r, sel_nak_r, disp_fault_r, busy_r;
    logic              chg_nxt_s, rej_nxt_s, nak_nxt_s, fault_nxt_s;
    logic              coin_evt_s;
    logic              idle_load_s, idle_en_s, idle_exp_s;
    logic              ack_load_s, ack_en_s, ack_exp_s;

    // Two-flop release synchroniser; FSM is held idle until it settles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign run_s      = rst_sync_r[1];
    assign coin_evt_s = (coin != COIN_NONE);
    assign sum_s      = credit_r + CW1'(coin_units(coin));

    // Per-slot price lookup.
    always_comb begin
        sel_price_s = CW1'(PRICE0);
        case (sel_slot)
            2'd0:    sel_price_s = CW1'(PRICE0);
            2'd1:    sel_price_s = CW1'(PRICE1);
            2'd2:    sel_price_s = CW1'(PRICE2);
            2'd3:    sel_price_s = CW1'(PRICE3);
            default: sel_price_s = CW1'(PRICE0);
        endcase
    end

    // Timers are held loaded outside their own state; any coin or selection restarts inactivity.
    assign idle_load_s = (state_r != ST_COLLECT) || coin_evt_s || sel_valid;
    assign idle_en_s   = (state_r == ST_COLLECT);
    assign ack_load_s  = (state_r != ST_VEND);
    assign ack_en_s    = (state_r == ST_VEND);

    vend_timer #(.W(IDLE_W), .LOAD_VAL(IDLE_TO)) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (idle_load_s),
        .en     (idle_en_s),
        .expire (idle_exp_s)
    );

    vend_timer #(.W(ACK_W), .LOAD_VAL(ACK_TO)) u_ack_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (ack_load_s),
        .en     (ack_en_s),
        .expire (ack_exp_s)
    );

    // Next-state, credit arithmetic and pulse outputs.
    always_comb begin
        state_nxt_s     = state_r;
        credit_nxt_s    = credit_r;
        price_nxt_s     = price_r;
        disp_slot_nxt_s = disp_slot_r;
        chg_nxt_s       = 1'b0;
        rej_nxt_s       = 1'b0;
        nak_nxt_s       = 1'b0;
        fault_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                nak_nxt_s = sel_valid;
                if (coin_evt_s) begin
                    if (sum_s <= MAX_C) begin
                        credit_nxt_s = sum_s;
                        state_nxt_s  = ST_COLLECT;
                    end else begin
                        rej_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (sel_valid && (credit_r >= sel_price_s)) begin
                    state_nxt_s     = ST_VEND;
                    disp_slot_nxt_s = sel_slot;
                    price_nxt_s     = sel_price_s;
                    rej_nxt_s       = coin_evt_s;
                end else begin
                    nak_nxt_s = sel_valid;
                    if (coin_evt_s) begin
                        if (sum_s <= MAX_C) begin
                            credit_nxt_s = sum_s;
                        end else begin
                            rej_nxt_s = 1'b1;
                        end
                    end else if (idle_exp_s) begin
                        state_nxt_s = ST_CHANGE;
                    end else begin
                        state_nxt_s = ST_COLLECT;
                    end
                end
            end
            ST_VEND: begin
                rej_nxt_s = coin_evt_s;
                if (disp_ack) begin
                    credit_nxt_s = credit_r - price_r;
                    state_nxt_s  = (credit_r == price_r) ? ST_IDLE : ST_CHANGE;
                end else if (ack_exp_s) begin
                    fault_nxt_s = 1'b1;
                    state_nxt_s = ST_CHANGE;
                end else begin
                    state_nxt_s = ST_VEND;
                end
            end
            ST_CHANGE: begin
                rej_nxt_s = coin_evt_s;
                if (credit_r != {CW1{1'b0}}) begin
                    chg_nxt_s    = 1'b1;
                    credit_nxt_s = credit_r - CW1'(1);
                    state_nxt_s  = (credit_r == CW1'(1)) ? ST_IDLE : ST_CHANGE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; cleared while the reset release settles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            credit_r     <= {CW1{1'b0}};
            price_r      <= {CW1{1'b0}};
            disp_slot_r  <= 2'b00;
            disp_req_r   <= 1'b0;
            chg_pulse_r  <= 1'b0;
            coin_rej_r   <= 1'b0;
            sel_nak_r    <= 1'b0;
            disp_fault_r <= 1'b0;
            busy_r       <= 1'b0;
        end else if (!run_s) begin
            state_r      <= ST_IDLE;
            credit_r     <= {CW1{1'b0}};
            price_r      <= {CW1{1'b0}};
            disp_slot_r  <= 2'b00;
            disp_req_r   <= 1'b0;
            chg_pulse_r  <= 1'b0;
            coin_rej_r   <= 1'b0;
            sel_nak_r    <= 1'b0;
            disp_fault_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            credit_r     <= credit_nxt_s;
            price_r      <= price_nxt_s;
            disp_slot_r  <= disp_slot_nxt_s;
            disp_req_r   <= (state_nxt_s == ST_VEND);
            chg_pulse_r  <= chg_nxt_s;
            coin_rej_r   <= rej_nxt_s;
            sel_nak_r    <= nak_nxt_s;
            disp_fault_r <= fault_nxt_s;
            busy_r       <= (state_nxt_s == ST_VEND) || (state_nxt_s == ST_CHANGE);
        end
    end

    assign disp_req   = disp_req_r;
    assign disp_slot  = disp_slot_r;
    assign chg_pulse  = chg_pulse_r;
    assign credit     = credit_r[CREDIT_W-1:0];
    assign coin_rej   = coin_rej_r;
    assign sel_nak    = sel_nak_r;
    assign disp_fault = disp_fault_r;
    assign busy       = busy_r;

endmodule
